sync_ram_burst_reader: RTL and testbench
========================================

Name: sync_ram_burst_reader

Overview:
- Read-side initiator for the team's single-ported synchronous-read RAMs, which have 1-cycle registered read latency.
- On a start command it reads `len` consecutive words beginning at `base_addr`.
- It presents the words in order on a ready/valid output stream.
- It absorbs the RAM read latency and downstream backpressure with an internal 4-entry buffer and credit-based address issue.
- Sits between a SYNC_RAM-style memory and a streaming consumer (e.g. UART TX path, DMA engine).

Parameters:
- DWIDTH, 32, RAM data width and output stream width.
- AWIDTH, 10, RAM address width; addresses wrap modulo 2^AWIDTH.
- LWIDTH, 11, burst length width; legal len is 0..2^AWIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  burst request; sampled only when busy=0
- base_addr  in  AWIDTH  first word address; sampled with start
- len  in  LWIDTH  number of words; sampled with start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- mem_addr  out  AWIDTH  RAM address; registered output
- mem_q  in  DWIDTH  RAM read data; valid 1 cycle after mem_addr
- out_data  out  DWIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer

Behaviour:
- Reset: clk, rst synchronous active-high. All of the following hold: busy=0, done=0, out_valid=0, out_data=0, mem_addr=0, state=IDLE, buffer empty, in-flight tracking cleared.
- States:
  - IDLE: start=1 with len>0 -> RUN. Latch the issue address (base_addr), remaining-issue count (len) and remaining-delivery count (len). busy=1 from the next cycle.
  - IDLE: start=1 with len=0 -> no RUN. done=1 for exactly the next cycle; busy stays 0; no reads, no output.
  - RUN: start is ignored; busy=1.
  - RUN -> IDLE: on the cycle with out_valid&&out_ready for the final word. In the next cycle busy=0 and done=1 (single cycle). A new start may be sampled in that done cycle.
- Address issue:
  - mem_addr is a register. An issue is a cycle in which mem_addr holds an address whose data will be captured.
  - Issue is allowed only when remaining-issue>0 and buf_count + inflight < 4.
  - inflight counts issues whose data has not yet been written to the buffer; it is at most 2.
  - After each issue, mem_addr increments by 1 modulo 2^AWIDTH.
  - When no issue occurs, mem_addr holds its value and any returned data is discarded.
- Timing:
  - start is sampled at edge k.
  - mem_addr=base_addr after edge k.
  - mem_q carries mem[base_addr] after edge k+1.
  - The word is captured into the buffer at edge k+2.
  - out_valid=1 with out_data=mem[base_addr] after edge k+2.
- Throughput: with out_ready held 1, one word per cycle sustained with no bubbles after the first.
- Buffer:
  - 4-entry FIFO, strict order.
  - out_data/out_valid come from the head entry; out_data is a register or head-entry read, not mem_q directly.
  - out_valid=1 exactly when the buffer is non-empty.
  - Once asserted, out_valid and out_data stay stable until the handshake.
  - Simultaneous capture and pop in the same cycle is supported; count is unchanged.
- Overflow: the credit rule guarantees the buffer never overflows. Assert in simulation that buf_count never exceeds 4.
- When out_valid=0, out_data holds its last value.
- Reset mid-burst: immediate return to IDLE. Buffer flushed, in-flight data discarded, no done pulse, out_valid=0 in the cycle after rst is sampled.
- Writes: the block never writes memory and provides no write port.

Test Plan:
- Basic burst, out_ready=1: RAM preloaded mem[i]=0x100+i; start at edge k with base=5, len=4 -> out_valid at edges k+2..k+5 with data 0x105, 0x106, 0x107, 0x108. done pulses once at k+6 with busy=0; busy=1 from k+1 through k+5.
- Backpressure: same burst with out_ready toggled 1,0,0,1,0,1,1… -> four words in order, no duplicates or drops. out_data stable while out_valid&&!out_ready. buf_count never exceeds 4. mem_addr stops advancing while the buffer is full.
- len=0: start, base=7 -> done=1 for one cycle after the start edge. busy, out_valid and mem_addr all stay 0.
- Address wrap: AWIDTH=10, base=1022, len=4 -> data from mem[1022], mem[1023], mem[0], mem[1], in order.
- Start while busy: second start (base=0, len=2) during a len=8 burst -> ignored. Exactly 8 words and one done pulse. A start asserted during the done cycle is accepted.
- Reset mid-burst: rst for 1 cycle after the 3rd word of a len=8 burst -> next cycle out_valid=0, busy=0, no done pulse. A fresh burst base=0, len=2 afterwards returns mem[0], mem[1] with no stale data.

Source files
------------

// File: rtl/sync_ram_burst_reader.sv
// Burst read initiator for 1-cycle-latency synchronous RAMs: issues len consecutive
// addresses from base_addr and streams the words out through a 4-entry buffer.
module sync_ram_burst_reader #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int LWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [LWIDTH-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_q,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [LWIDTH-1:0] issue_rem, deliver_rem;
    logic              iss_q;    // mem_addr currently holds an issued address
    logic              rd_pend;  // mem_q carries issued data this cycle
    logic [DWIDTH-1:0] fifo [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        buf_count;
    logic [3:0]        credit_use;
    logic              start_go, start_empty, issue_ok, pop, capture, last_pop;

    assign busy        = (state == RUN);
    assign out_valid   = (buf_count != 3'd0);
    assign pop         = out_valid && out_ready;
    assign capture     = rd_pend;
    assign start_go    = (state == IDLE) && start && (len != '0);
    assign start_empty = (state == IDLE) && start && (len == '0);
    assign last_pop    = (state == RUN) && pop && (deliver_rem == LWIDTH'(1));

    // Occupancy after this edge counting data still in the RAM pipe; a new issue
    // is allowed only if the buffer can still hold every word in flight.
    assign credit_use = 4'(buf_count) + 4'(iss_q) + 4'(rd_pend) - 4'(pop);
    assign issue_ok   = (state == RUN) && (issue_rem != '0) && (credit_use < 4'd4);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = RUN;
            RUN:     if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            iss_q       <= 1'b0;
            rd_pend     <= 1'b0;
            mem_addr    <= '0;
            issue_rem   <= '0;
            deliver_rem <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            buf_count   <= '0;
            out_data    <= '0;
        end else begin
            done    <= last_pop || start_empty;
            iss_q   <= start_go || issue_ok;
            rd_pend <= iss_q;

            if (start_go) begin
                mem_addr    <= base_addr;
                issue_rem   <= len - LWIDTH'(1);
                deliver_rem <= len;
            end else begin
                if (issue_ok) begin
                    mem_addr  <= mem_addr + AWIDTH'(1);
                    issue_rem <= issue_rem - LWIDTH'(1);
                end
                if (pop) deliver_rem <= deliver_rem - LWIDTH'(1);
            end

            if (capture) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            buf_count <= buf_count + 3'(capture) - 3'(pop);

            // out_data mirrors the head entry and holds when the buffer drains
            if (pop && buf_count >= 3'd2)
                out_data <= fifo[rd_ptr + 2'd1];
            else if (capture && (buf_count == 3'd0 || (pop && buf_count == 3'd1)))
                out_data <= mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifo[wr_ptr] <= mem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (buf_count <= 3'd4);
    end

endmodule

// File: tb/tb_sync_ram_burst_reader.sv
// Self-checking bench: table of bursts driven through a scoreboard, plus hand
// sequences for timing, len=0, backpressure stall, start-while-busy and reset.
module tb_sync_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        busy, done, out_valid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_q, out_data;
    logic        out_ready = 1'b1;

    sync_ram_burst_reader #(.DWIDTH(32), .AWIDTH(10), .LWIDTH(11)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_q(mem_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
    always @(posedge clk) mem_q <= mem[mem_addr];

    int n_cmp = 0;
    int n_err = 0;
    int words = 0;
    int done_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ready pattern: 0 always, 1 fixed toggle, 2 random, 3 held low
    int rmode = 0;
    int pidx = 0;
    logic [6:0] pat = 7'b1101001;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 7; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("valid_held", {31'd0, out_valid}, 32'd1);
                check("data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                words++;
                last_word = out_data;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    check("word", out_data, sb.pop_front());
                end
            end
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic pulse_start(input logic [9:0] b, input int l);
        start = 1'b1; base_addr = b; len = 11'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_burst(input logic [9:0] b, input int l);
        for (int i = 0; i < l; i++) sb.push_back(mem[(int'(b) + i) % 1024]);
        @(posedge clk); #1;
        pulse_start(b, l);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no done expected done within %0d", name, budget);
        end
    endtask

    task automatic finish_burst(input int l, input int d0, input int w0, input string name);
        wait_done(l * 8 + 40, name);
        @(negedge clk);
        check({name, "_words"}, 32'(words - w0), 32'(l));
        check({name, "_dones"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [9:0]  base;
        int          len;
        int          mode;
        logic [31:0] exp_last;
    } vec_t;
    vec_t vecs[8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, n;
        vecs[0] = '{10'd5,    4,    0, 32'h108};
        vecs[1] = '{10'd5,    4,    1, 32'h108};
        vecs[2] = '{10'd1022, 4,    0, 32'h101};
        vecs[3] = '{10'd1020, 6,    2, 32'h101};
        vecs[4] = '{10'd0,    1,    0, 32'h100};
        vecs[5] = '{10'd300,  16,   1, 32'h23B};
        vecs[6] = '{10'd1023, 1,    2, 32'h4FF};
        vecs[7] = '{10'd512,  1024, 0, 32'h2FF};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // len = 0
        @(posedge clk); #1;
        d0 = done_cnt;
        pulse_start(10'd7, 0);
        @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_valid", {31'd0, out_valid}, 32'd0);
        check("len0_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        check("len0_done_off", {31'd0, done}, 32'd0);
        check("len0_addr2", 32'(mem_addr), 32'd0);
        check("len0_dones", 32'(done_cnt - d0), 32'd1);

        // exact timing of a basic burst
        for (int i = 0; i < 4; i++) sb.push_back(32'h105 + i);
        @(posedge clk); #1;
        pulse_start(10'd5, 4);
        @(negedge clk);
        check("t_k_busy", {31'd0, busy}, 32'd1);
        check("t_k_addr", 32'(mem_addr), 32'd5);
        check("t_k_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t_k1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t_k2_valid", {31'd0, out_valid}, 32'd1);
        check("t_k2_data", out_data, 32'h105);
        repeat (3) @(negedge clk);
        check("t_k5_busy", {31'd0, busy}, 32'd1);
        check("t_k5_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t_k6_done", {31'd0, done}, 32'd1);
        check("t_k6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t_k7_done", {31'd0, done}, 32'd0);
        check("t_sb_empty", 32'(sb.size()), 32'd0);

        // table of bursts
        for (int v = 0; v < 8; v++) begin
            rmode = vecs[v].mode;
            d0 = done_cnt; w0 = words;
            start_burst(vecs[v].base, vecs[v].len);
            finish_burst(vecs[v].len, d0, w0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_last", v), last_word, vecs[v].exp_last);
            rmode = 0;
        end

        // full buffer stalls the address
        rmode = 3; out_ready = 1'b0;
        d0 = done_cnt; w0 = words;
        start_burst(10'd40, 8);
        repeat (10) @(negedge clk);
        check("stall_addr", 32'(mem_addr), 32'd43);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_head", out_data, 32'h128);
        rmode = 0;
        finish_burst(8, d0, w0, "stall");

        // start while busy ignored; start in the done cycle accepted
        rmode = 1;
        d0 = done_cnt; w0 = words;
        start_burst(10'd100, 8);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; base_addr = 10'd0; len = 11'd2;
        @(posedge clk); #1 start = 1'b0;
        wait_done(120, "busy_start");
        check("busy_start_words", 32'(words - w0), 32'd8);
        check("busy_start_sb", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) sb.push_back(mem[200 + i]);
        start = 1'b1; base_addr = 10'd200; len = 11'd3;
        @(posedge clk); #1 start = 1'b0;
        finish_burst(3, d0 + 1, w0 + 8, "done_cycle_start");
        rmode = 0;

        // reset in the middle of a burst
        d0 = done_cnt; w0 = words;
        start_burst(10'd10, 8);
        n = 0;
        while (words - w0 < 3 && n < 60) begin @(negedge clk); n++; end
        check("mid_rst_reach3", 32'(words - w0), 32'd3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        d0 = done_cnt; w0 = words;
        start_burst(10'd0, 2);
        finish_burst(2, d0, w0, "post_rst");
        check("post_rst_last", last_word, 32'h101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
